ex_mem_loader: RTL and testbench

//  Host-side initiator for the core's external memory-load interface. Receives a

---
 rtl/ex_mem_loader_if.sv | 25 ++
 rtl/ex_mem_loader.sv | 91 +++++++++
 tb/tb_ex_mem_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_loader_if.sv
// ex_mem_loader_if: word stream in plus paired-word load buses out to the riscv external memory port
interface ex_mem_loader_if #(parameter int DATA_W = 32, parameter int DM_ADDRESS = 9);
  logic                  s_valid;
  logic [DATA_W-1:0]     s_data;
  logic                  s_ready;
  logic                  enable_load_ex_mem;
  logic [DM_ADDRESS-1:0] InstExMemAddress;
  logic [DATA_W-1:0]     InstExMemData1;
  logic [DATA_W-1:0]     InstExMemData2;
  logic [DM_ADDRESS-1:0] DataExMemAddress;
  logic [DATA_W-1:0]     DataExMemData1;
  logic [DATA_W-1:0]     DataExMemData2;
  modport master (
    input  s_valid, s_data,
    output s_ready, enable_load_ex_mem,
    output InstExMemAddress, InstExMemData1, InstExMemData2,
    output DataExMemAddress, DataExMemData1, DataExMemData2
  );
  modport slave (
    output s_valid, s_data,
    input  s_ready, enable_load_ex_mem,
    input  InstExMemAddress, InstExMemData1, InstExMemData2,
    input  DataExMemAddress, DataExMemData1, DataExMemData2
  );
endinterface

// File: rtl/ex_mem_loader.sv
// ex_mem_loader: packs a 32-bit word stream into pairs and strobes them into riscv inst/data memory
module ex_mem_loader #(
  parameter int                 DATA_W     = 32,
  parameter int                 DM_ADDRESS = 9,
  parameter logic [DATA_W-1:0]  PAD_WORD   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mem_sel,
  input  logic [DM_ADDRESS-1:0] base_addr,
  input  logic [DM_ADDRESS:0]   word_count,
  ex_mem_loader_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, W1, W2, WR, FIN} state_t;
  state_t state, nxt;
  logic                  msel;
  logic [DM_ADDRESS-1:0] addr;
  logic [DM_ADDRESS:0]   rem;
  logic [DATA_W-1:0]     d1, d2;
  logic [DM_ADDRESS+1:0] end_addr;
  logic                  bad, hs, last;
  assign end_addr = {2'b00, base_addr} + {1'b0, word_count};
  assign bad      = base_addr[0] | (end_addr > {2'b01, {DM_ADDRESS{1'b0}}});
  assign hs       = bus.s_valid & bus.s_ready;
  assign last     = rem == {{DM_ADDRESS{1'b0}}, 1'b1};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = start ? ((bad || word_count == '0) ? FIN : W1) : IDLE;
        W1:      nxt = hs ? (last ? WR : W2) : W1;
        W2:      nxt = hs ? WR : W2;
        WR:      nxt = (rem == '0) ? FIN : W1;
        FIN:     nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  // abort suppresses every visible effect in the cycle it is seen
  always_comb begin
    bus.s_ready            = (state == W1 || state == W2) && !abort;
    bus.enable_load_ex_mem = (state == WR) && !abort;
    done                   = (state == FIN) && !abort;
    busy                   = state == W1 || state == W2 || state == WR;
    bus.InstExMemAddress   = msel ? '0 : addr;
    bus.InstExMemData1     = msel ? '0 : d1;
    bus.InstExMemData2     = msel ? '0 : d2;
    bus.DataExMemAddress   = msel ? addr : '0;
    bus.DataExMemData1     = msel ? d1 : '0;
    bus.DataExMemData2     = msel ? d2 : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msel <= 1'b0;
      addr <= '0;
      rem  <= '0;
      d1   <= '0;
      d2   <= '0;
      err  <= 1'b0;
    end else if (!abort) begin
      case (state)
        IDLE: if (start) begin
          msel <= mem_sel;
          addr <= base_addr;
          rem  <= word_count;
          err  <= bad;
        end
        W1: if (hs) begin
          d1  <= bus.s_data;
          rem <= rem - 1'b1;
          if (last) d2 <= PAD_WORD;
        end
        W2: if (hs) begin
          d2  <= bus.s_data;
          rem <= rem - 1'b1;
        end
        WR: addr <= addr + DM_ADDRESS'(2);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_mem_loader.sv
// tb_ex_mem_loader: directed scenarios for ex_mem_loader with hand-computed strobe contents
module tb_ex_mem_loader;
  logic clk = 0, reset = 0, start = 0, abort = 0, mem_sel = 0;
  logic [8:0] base_addr = 0;
  logic [9:0] word_count = 0;
  logic busy, done, err;
  int n_cmp = 0, n_bad = 0;
  int nstb = 0, ndone = 0, nrdy = 0, cyc = 0;
  logic [8:0]  ia [16], da [16];
  logic [31:0] i1 [16], i2 [16], d1 [16], d2 [16];
  int          sc [16];
  ex_mem_loader_if bus ();
  ex_mem_loader dut (.clk(clk), .reset(reset), .start(start), .abort(abort), .mem_sel(mem_sel),
    .base_addr(base_addr), .word_count(word_count), .bus(bus), .busy(busy), .done(done), .err(err));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.s_ready) nrdy++;
    if (done) ndone++;
    if (bus.enable_load_ex_mem && nstb < 16) begin
      ia[nstb] = bus.InstExMemAddress; i1[nstb] = bus.InstExMemData1; i2[nstb] = bus.InstExMemData2;
      da[nstb] = bus.DataExMemAddress; d1[nstb] = bus.DataExMemData1; d2[nstb] = bus.DataExMemData2;
      sc[nstb] = cyc;
    end
    if (bus.enable_load_ex_mem) nstb++;
  end
  task go(input logic sel, input logic [8:0] b, input logic [9:0] n);
    @(negedge clk);
    mem_sel = sel; base_addr = b; word_count = n; start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task push(input logic [31:0] w);
    int t;
    t = 0;
    bus.s_data = w; bus.s_valid = 1;
    while (!bus.s_ready && t < 50) begin @(negedge clk); t++; end
    n_cmp++;
    if (t >= 50) begin n_bad++; $display("FAIL push_timeout: s_ready low %0d cycles, need high", t); end
    @(negedge clk);
    bus.s_valid = 0;
  endtask
  task wait_done(input int d0);
    int t;
    t = 0;
    while (ndone == d0 && t < 40) begin @(negedge clk); t++; end
  endtask
  task test_reset;
    bus.s_valid = 1; bus.s_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, bus.s_ready, bus.enable_load_ex_mem} !== 5'b0) begin
      n_bad++; $display("FAIL reset_held: flags %b, need 00000", {busy, done, err, bus.s_ready, bus.enable_load_ex_mem});
    end
    reset = 1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({busy, done, err, bus.s_ready, bus.enable_load_ex_mem} !== 5'b0 || nrdy !== 0) begin
      n_bad++; $display("FAIL reset_idle: flags %b nrdy %0d, need 0/0", {busy, done, err, bus.s_ready, bus.enable_load_ex_mem}, nrdy);
    end
    n_cmp++;
    if ({bus.InstExMemAddress, bus.InstExMemData1, bus.InstExMemData2, bus.DataExMemAddress, bus.DataExMemData1, bus.DataExMemData2} !== '0) begin
      n_bad++; $display("FAIL reset_buses: inst %h %h %h data %h %h %h, need 0", bus.InstExMemAddress, bus.InstExMemData1,
        bus.InstExMemData2, bus.DataExMemAddress, bus.DataExMemData1, bus.DataExMemData2);
    end
    bus.s_valid = 0;
  endtask
  task test_inst_load;
    int s0, q0;
    s0 = nstb; q0 = ndone;
    go(0, 0, 4);
    n_cmp++;
    if (busy !== 1) begin n_bad++; $display("FAIL inst_busy: got %b need 1", busy); end
    push(32'hA); push(32'hB); push(32'hC); push(32'hD);
    wait_done(q0);
    n_cmp++;
    if (nstb - s0 !== 2 || ndone - q0 !== 1) begin
      n_bad++; $display("FAIL inst_counts: strobes %0d done %0d, need 2/1", nstb - s0, ndone - q0);
    end
    n_cmp++;
    if ({ia[s0], i1[s0], i2[s0]} !== {9'd0, 32'hA, 32'hB}) begin
      n_bad++; $display("FAIL inst_pair0: %h %h %h, need 0 a b", ia[s0], i1[s0], i2[s0]);
    end
    n_cmp++;
    if ({ia[s0+1], i1[s0+1], i2[s0+1]} !== {9'd2, 32'hC, 32'hD}) begin
      n_bad++; $display("FAIL inst_pair1: %h %h %h, need 2 c d", ia[s0+1], i1[s0+1], i2[s0+1]);
    end
    n_cmp++;
    if ({da[s0], d1[s0], d2[s0], da[s0+1], d1[s0+1], d2[s0+1]} !== '0) begin
      n_bad++; $display("FAIL inst_data_bus_zero: %h %h %h, need 0", da[s0], d1[s0], d2[s0]);
    end
    n_cmp++;
    if (sc[s0+1] - sc[s0] !== 3) begin
      n_bad++; $display("FAIL throughput: strobe gap %0d cycles, need 3", sc[s0+1] - sc[s0]);
    end
  endtask
  task test_data_odd;
    int s0, q0;
    s0 = nstb; q0 = ndone;
    go(1, 8, 3);
    push(32'h1); push(32'h2); push(32'h3);
    wait_done(q0);
    n_cmp++;
    if (nstb - s0 !== 2 || ndone - q0 !== 1 || err !== 0) begin
      n_bad++; $display("FAIL odd_counts: strobes %0d done %0d err %b, need 2/1/0", nstb - s0, ndone - q0, err);
    end
    n_cmp++;
    if ({da[s0], d1[s0], d2[s0]} !== {9'd8, 32'h1, 32'h2}) begin
      n_bad++; $display("FAIL odd_pair0: %h %h %h, need 8 1 2", da[s0], d1[s0], d2[s0]);
    end
    n_cmp++;
    if ({da[s0+1], d1[s0+1], d2[s0+1]} !== {9'd10, 32'h3, 32'h13}) begin
      n_bad++; $display("FAIL odd_pad: %h %h %h, need a 3 13", da[s0+1], d1[s0+1], d2[s0+1]);
    end
    n_cmp++;
    if ({ia[s0+1], i1[s0+1], i2[s0+1]} !== '0) begin
      n_bad++; $display("FAIL odd_inst_bus_zero: %h %h %h, need 0", ia[s0+1], i1[s0+1], i2[s0+1]);
    end
  endtask
  task test_range_err;
    int s0, q0;
    s0 = nstb; q0 = ndone;
    go(0, 3, 2);
    wait_done(q0);
    n_cmp++;
    if (err !== 1 || ndone - q0 !== 1 || nstb !== s0) begin
      n_bad++; $display("FAIL err_odd_base: err %b done %0d strobes %0d, need 1/1/0", err, ndone - q0, nstb - s0);
    end
    q0 = ndone;
    go(0, 510, 4);
    wait_done(q0);
    n_cmp++;
    if (err !== 1 || ndone - q0 !== 1 || nstb !== s0) begin
      n_bad++; $display("FAIL err_overflow: err %b done %0d strobes %0d, need 1/1/0", err, ndone - q0, nstb - s0);
    end
    q0 = ndone;
    go(0, 510, 2);
    n_cmp++;
    if (err !== 0) begin n_bad++; $display("FAIL err_clear: err %b, need 0", err); end
    push(32'h55); push(32'h66);
    wait_done(q0);
    n_cmp++;
    if (nstb - s0 !== 1 || {ia[s0], i1[s0], i2[s0]} !== {9'd510, 32'h55, 32'h66}) begin
      n_bad++; $display("FAIL top_edge: strobes %0d %h %h %h, need 1 1fe 55 66", nstb - s0, ia[s0], i1[s0], i2[s0]);
    end
  endtask
  task test_zero_count;
    int s0, q0, r0;
    s0 = nstb; q0 = ndone; r0 = nrdy;
    bus.s_valid = 1; bus.s_data = 32'h77;
    go(0, 4, 0);
    n_cmp++;
    if (done !== 1) begin n_bad++; $display("FAIL zero_done_timing: done %b, need 1", done); end
    repeat (3) @(negedge clk);
    bus.s_valid = 0;
    n_cmp++;
    if (ndone - q0 !== 1 || nstb !== s0 || nrdy !== r0 || err !== 0) begin
      n_bad++; $display("FAIL zero_count: done %0d strobes %0d ready %0d err %b, need 1/0/0/0", ndone - q0, nstb - s0, nrdy - r0, err);
    end
  endtask
  task test_abort_reset;
    int s0, q0;
    s0 = nstb; q0 = ndone;
    go(0, 0, 4);
    push(32'h11);
    abort = 1; bus.s_valid = 1; bus.s_data = 32'h22;
    @(negedge clk);
    abort = 0; bus.s_valid = 0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (busy !== 0 || nstb !== s0 || ndone !== q0) begin
      n_bad++; $display("FAIL abort: busy %b strobes %0d done %0d, need 0/0/0", busy, nstb - s0, ndone - q0);
    end
    go(1, 2, 2);
    push(32'h5); push(32'h6);
    wait_done(q0);
    n_cmp++;
    if (nstb - s0 !== 1 || {da[s0], d1[s0], d2[s0]} !== {9'd2, 32'h5, 32'h6}) begin
      n_bad++; $display("FAIL after_abort: strobes %0d %h %h %h, need 1 2 5 6", nstb - s0, da[s0], d1[s0], d2[s0]);
    end
    s0 = nstb; q0 = ndone;
    go(0, 0, 4);
    push(32'h33);
    #2 reset = 0;
    #1;
    n_cmp++;
    if ({busy, bus.s_ready, bus.enable_load_ex_mem, done} !== 4'b0) begin
      n_bad++; $display("FAIL async_reset: busy/rdy/stb/done %b, need 0000", {busy, bus.s_ready, bus.enable_load_ex_mem, done});
    end
    @(negedge clk);
    reset = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (nstb !== s0 || ndone !== q0) begin
      n_bad++; $display("FAIL async_reset_quiet: strobes %0d done %0d, need 0/0", nstb - s0, ndone - q0);
    end
    go(0, 4, 2);
    push(32'h7); push(32'h8);
    wait_done(q0);
    n_cmp++;
    if (nstb - s0 !== 1 || {ia[s0], i1[s0], i2[s0]} !== {9'd4, 32'h7, 32'h8}) begin
      n_bad++; $display("FAIL after_reset: strobes %0d %h %h %h, need 1 4 7 8", nstb - s0, ia[s0], i1[s0], i2[s0]);
    end
  endtask
  initial begin
    bus.s_valid = 0; bus.s_data = 0;
    test_reset;
    test_inst_load;
    test_data_odd;
    test_range_err;
    test_zero_count;
    test_abort_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
